// File: rtl/alu_result_demux_if.sv
// ============================================================================
// alu_result_demux_if : ALU result input bus plus four channel output handshakes.
// Rev 1.0 | optional macro DEMUX_CNT_EN adds cnt_o (per-channel push counters).
// ============================================================================
`default_nettype none

interface alu_result_demux_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       S_i;
   logic [WIDTH-1:0] D_i;
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] M_o;
   logic [WIDTH-1:0] J_o;
   logic [WIDTH-1:0] L_o;
   logic [WIDTH-1:0] K_o;
   logic [3:0]       vld_o;
   logic [3:0]       rdy_i;
`ifdef DEMUX_CNT_EN
   logic [31:0]      cnt_o;
`endif

   modport slave (
      input  S_i, D_i, valid_i, rdy_i,
      output ready_o, M_o, J_o, L_o, K_o, vld_o
`ifdef DEMUX_CNT_EN
      , output cnt_o
`endif
   );

   modport master (
      output S_i, D_i, valid_i, rdy_i,
      input  ready_o, M_o, J_o, L_o, K_o, vld_o
`ifdef DEMUX_CNT_EN
      , input cnt_o
`endif
   );
endinterface

`default_nettype wire

// File: rtl/alu_result_demux.sv
// ============================================================================
// alu_result_demux : routes an ALU result to one of four FIFO-buffered channels.
// Rev 1.0 | optional macro DEMUX_CNT_EN adds per-channel push counters on cnt_o.
// ============================================================================
`default_nettype none

module alu_result_demux #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input wire logic          clk_i,
   input wire logic          rst_i,
   alu_result_demux_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0]    w_count [4];
   logic [WIDTH-1:0] w_head  [4];
   logic             w_vld   [4];
   logic             w_push;
   logic             w_sel_room;

   // A full channel still accepts when its head leaves in the same cycle.
   assign w_sel_room  = (w_count[bus.S_i] != CW'(DEPTH)) || bus.rdy_i[bus.S_i];
   assign bus.ready_o = !rst_i && w_sel_room;
   assign w_push      = bus.valid_i && bus.ready_o;

   for (genvar c = 0; c < 4; c++) begin : g_ch
      logic [PW-1:0]    wptr_q, wptr_d;
      logic [PW-1:0]    rptr_q, rptr_d;
      logic [CW-1:0]    count_q, count_d;
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic             w_ch_push;
      logic             w_ch_pop;

      assign w_ch_push = w_push && (bus.S_i == 2'(c));
      assign w_ch_pop  = (count_q != '0) && bus.rdy_i[c];

      always_comb begin
         wptr_d  = wptr_q;
         rptr_d  = rptr_q;
         count_d = count_q;
         if (w_ch_push) wptr_d = wptr_q + PW'(1);
         if (w_ch_pop)  rptr_d = rptr_q + PW'(1);
         case ({w_ch_push, w_ch_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
         end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
         end
      end

      // Storage is not reset; the output is masked to zero while empty.
      always_ff @(posedge clk_i) begin
         if (w_ch_push) mem_q[wptr_q] <= bus.D_i;
      end

      assign w_count[c] = count_q;
      assign w_vld[c]   = (count_q != '0);
      assign w_head[c]  = w_vld[c] ? mem_q[rptr_q] : '0;
   end

   assign bus.vld_o = {w_vld[3], w_vld[2], w_vld[1], w_vld[0]};
   assign bus.M_o   = w_head[0];
   assign bus.J_o   = w_head[1];
   assign bus.L_o   = w_head[2];
   assign bus.K_o   = w_head[3];

`ifdef DEMUX_CNT_EN
   logic [7:0] w_pcnt [4];

   for (genvar c = 0; c < 4; c++) begin : g_cnt
      logic [7:0] pcnt_q, pcnt_d;

      assign pcnt_d = g_ch[c].w_ch_push ? pcnt_q + 8'd1 : pcnt_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) pcnt_q <= '0;
         else       pcnt_q <= pcnt_d;
      end

      assign w_pcnt[c] = pcnt_q;
   end

   assign bus.cnt_o = {w_pcnt[3], w_pcnt[2], w_pcnt[1], w_pcnt[0]};
`endif
endmodule

`default_nettype wire

// File: tb/tb_alu_result_demux.sv
// ============================================================================
// tb_alu_result_demux : directed self-checking bench for alu_result_demux.
// Rev 1.0 | build with +define+DEMUX_CNT_EN to also check cnt_o.
// ============================================================================
`default_nettype none

module tb_alu_result_demux;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   alu_result_demux_if #(.WIDTH(8)) bus ();

   alu_result_demux #(.WIDTH(8), .DEPTH(2)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] s, input logic [7:0] d);
      bus.S_i     = s;
      bus.D_i     = d;
      bus.valid_i = 1'b1;
      tick();
      bus.valid_i = 1'b0;
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus.S_i     = 2'b00;
      bus.D_i     = 8'h00;
      bus.valid_i = 1'b0;
      bus.rdy_i   = 4'b0000;
      #1;
      check("ready_in_reset", 32'(bus.ready_o), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Idle after reset
      check("idle_vld", 32'(bus.vld_o), 32'h0);
      check("idle_M", 32'(bus.M_o), 32'h0);
      check("idle_J", 32'(bus.J_o), 32'h0);
      check("idle_L", 32'(bus.L_o), 32'h0);
      check("idle_K", 32'(bus.K_o), 32'h0);
      for (int s = 0; s < 4; s++) begin
         bus.S_i = 2'(s);
         #1;
         check($sformatf("idle_ready_s%0d", s), 32'(bus.ready_o), 32'd1);
      end

      // Single word to J
      push(2'b01, 8'hA5);
      check("j_vld", 32'(bus.vld_o), 32'h2);
      check("j_data", 32'(bus.J_o), 32'hA5);
      check("j_M_zero", 32'(bus.M_o), 32'h0);
      check("j_L_zero", 32'(bus.L_o), 32'h0);
      check("j_K_zero", 32'(bus.K_o), 32'h0);
      bus.rdy_i = 4'b0010;
      tick();
      bus.rdy_i = 4'b0000;
      check("j_drained", 32'(bus.vld_o), 32'h0);

      // Fill K, check backpressure and blocked push leaves state untouched
      push(2'b11, 8'h11);
      push(2'b11, 8'h22);
      bus.S_i = 2'b11;
      #1;
      check("k_full_ready", 32'(bus.ready_o), 32'd0);
      bus.S_i = 2'b00;
      #1;
      check("m_ready_while_k_full", 32'(bus.ready_o), 32'd1);
      push(2'b11, 8'h99);
      bus.rdy_i = 4'b1000;
      #1;
      check("k_head0", 32'(bus.K_o), 32'h11);
      tick();
      check("k_head1", 32'(bus.K_o), 32'h22);
      tick();
      check("k_empty", 32'(bus.vld_o[3]), 32'd0);
      check("k_empty_data", 32'(bus.K_o), 32'h0);
      bus.rdy_i = 4'b0000;

      // Full L with simultaneous push and pop
      push(2'b10, 8'h01);
      push(2'b10, 8'h02);
      bus.S_i     = 2'b10;
      bus.D_i     = 8'h03;
      bus.valid_i = 1'b1;
      bus.rdy_i   = 4'b0100;
      #1;
      check("l_full_pop_ready", 32'(bus.ready_o), 32'd1);
      check("l_head0", 32'(bus.L_o), 32'h01);
      tick();
      bus.valid_i = 1'b0;
      bus.rdy_i   = 4'b0000;
      #1;
      check("l_still_full", 32'(bus.ready_o), 32'd0);
      check("l_head1", 32'(bus.L_o), 32'h02);
      bus.rdy_i = 4'b0100;
      tick();
      check("l_head2", 32'(bus.L_o), 32'h03);
      tick();
      check("l_empty", 32'(bus.vld_o), 32'h0);
      bus.rdy_i = 4'b0000;

      // Simultaneous pop on M and J
      push(2'b00, 8'hAA);
      push(2'b00, 8'hBB);
      push(2'b01, 8'hCC);
      push(2'b01, 8'hDD);
      check("mj_vld", 32'(bus.vld_o), 32'h3);
      bus.rdy_i = 4'b0011;
      tick();
      bus.rdy_i = 4'b0000;
      check("mj_M_after_pop", 32'(bus.M_o), 32'hBB);
      check("mj_J_after_pop", 32'(bus.J_o), 32'hDD);
      check("mj_vld_after_pop", 32'(bus.vld_o), 32'h3);
      bus.rdy_i = 4'b0011;
      tick();
      bus.rdy_i = 4'b0000;
      check("mj_drained", 32'(bus.vld_o), 32'h0);

      // Three words to M, then reset mid-drain
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push(2'b00, 8'h31);
      push(2'b00, 8'h32);
      bus.rdy_i = 4'b0001;
      push(2'b00, 8'h33);
      check("m3_head", 32'(bus.M_o), 32'h32);
`ifdef DEMUX_CNT_EN
      check("cnt_before_rst", 32'(bus.cnt_o[7:0]), 32'd3);
`endif
      rst         = 1'b1;
      bus.S_i     = 2'b00;
      bus.D_i     = 8'h44;
      bus.valid_i = 1'b1;
      #1;
      check("ready_mid_rst", 32'(bus.ready_o), 32'd0);
      tick();
      rst         = 1'b0;
      bus.valid_i = 1'b0;
      bus.rdy_i   = 4'b0000;
      check("rst_vld", 32'(bus.vld_o), 32'h0);
      check("rst_M", 32'(bus.M_o), 32'h0);
`ifdef DEMUX_CNT_EN
      check("cnt_after_rst", bus.cnt_o, 32'd0);
`endif
      push(2'b00, 8'h55);
      check("post_rst_M", 32'(bus.M_o), 32'h55);
      check("post_rst_vld", 32'(bus.vld_o), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
